// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

  localparam int          ITER    = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Magnitude of a signed operand; unsigned ops pass the raw value through.
  function automatic logic [31:0] op_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_muldiv_div_step.sv
// One restoring-divide step on a {remainder, dividend/quotient} pair.
module muldiv_div_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] quo_out
);

  logic [32:0] trial;
  logic [32:0] diff;
  logic        ge;

  // The next dividend bit enters the remainder; the quotient bit fills in at the bottom.
  assign trial   = {rem_in, quo_in[31]};
  assign ge      = trial >= {1'b0, divisor};
  assign diff    = trial - {1'b0, divisor};
  assign rem_out = ge ? diff[31:0] : trial[31:0];
  assign quo_out = {quo_in[30:0], ge};

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Optional MULDIV_FAST_MULT_EN: single-cycle combinational multiply path.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int ITER = mips_muldiv_pkg::ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc_q;
  logic [5:0]  cnt_q;
  logic        neg_lo_q, neg_hi_q, div0_q;
  logic [31:0] hi_q, lo_q;

  logic        is_div;
  logic        op_signed;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] msum;
  logic [31:0] rem_n, quo_n;
  logic [63:0] mul_raw, mul_res;
  logic [31:0] q_res, r_res;

`ifdef MULDIV_FAST_MULT_EN
  localparam logic FAST_MULT = 1'b1;
  assign mul_raw = 64'(a_q) * 64'(b_q);
`else
  localparam logic FAST_MULT = 1'b0;
  assign mul_raw = acc_q;
`endif

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign op_signed = ~op[0];
  assign rs_mag    = op_mag(rs_data, op_signed);
  assign rt_mag    = op_mag(rt_data, op_signed);

  // Radix-2 shift-add: conditionally add multiplicand to the upper half, then shift right.
  assign msum = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);

  muldiv_div_step u_div_step (
    .rem_in  (acc_q[63:32]),
    .quo_in  (acc_q[31:0]),
    .divisor (a_q),
    .rem_out (rem_n),
    .quo_out (quo_n)
  );

  assign mul_res = neg_lo_q ? (~mul_raw + 64'd1) : mul_raw;
  // Divide by zero leaves |rs| in the remainder, so the sign fix restores rs itself.
  assign q_res   = div0_q ? DIV0_LO : (neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
  assign r_res   = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (start) state_d = (FAST_MULT && !op[1]) ? S_FIX : S_RUN;
      S_RUN:  if (cnt_q == 6'(ITER - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (clk_enable) begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q     <= op_e'(op);
            a_q      <= rt_mag;
            b_q      <= rs_mag;
            // Divides keep the dividend in the low half, consumed MSB first.
            acc_q    <= {32'd0, op[1] ? rs_mag : 32'd0};
            cnt_q    <= '0;
            neg_lo_q <= op_signed & (rs_data[31] ^ rt_data[31]);
            neg_hi_q <= op_signed & rs_data[31];
            div0_q   <= op[1] & (rt_data == 32'd0);
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 6'd1;
          if (is_div) begin
            acc_q <= {rem_n, quo_n};
          end else begin
            acc_q <= {msum, acc_q[31:1]};
            b_q   <= b_q >> 1;
          end
        end
        S_FIX: begin
          if (is_div) begin
            hi_q <= r_res;
            lo_q <= q_res;
          end else begin
            {hi_q, lo_q} <= mul_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit owning the architectural HI/LO registers.
- Sits beside the ALU, downstream of decode/regfile read ports: takes rs/rt operands for MULT/MULTU/DIV/DIVU.
- Supplies HI/LO to the writeback mux for MFHI/MFLO.
- Raises busy so the CPU stalls PC/regfile until the result lands.

Parameters:
- ITER, 32, number of iteration cycles for multiply and divide (bits processed per op; fixed at 32 for MIPS32).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- clk_enable  input  1  global enable; when low, all state holds and all requests are ignored
- start  input  1  request a new mult/div; sampled only when busy=0
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- rs_data  input  32  multiplicand / dividend
- rt_data  input  32  multiplier / divisor
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  32  MTHI/MTLO data
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, state=IDLE, iteration counter=0.
- Only edges with clk_enable=1 act; with clk_enable=0, every register holds.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1 (edge E0):
  - Latch op.
  - Latch operand magnitudes: abs() for MULT/DIV, raw for MULTU/DIVU.
  - Latch result sign: MULT = rs[31]^rt[31]; DIV quotient = rs[31]^rt[31]; DIV remainder = rs[31].
  - Clear the 64-bit accumulator; counter=0; go to RUN; busy=1 from after E0.
- RUN: one bit per edge.
  - Multiply: shift-add radix-2.
  - Divide: restoring, one quotient bit per edge.
  - After ITER edges (E1..E32), go to FIX.
- FIX (edge E33):
  - Apply sign correction via two's complement.
  - Write hi/lo; go to IDLE; busy=0.
  - Result is visible on hi/lo the cycle after E33, so busy is high for exactly 33 cycles.
- Results:
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder; remainder sign follows dividend; quotient truncates toward zero.
- Divide by zero (rt=0), DIV or DIVU: normal latency, hi=rs_data (original value), lo=32'hFFFFFFFF.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0; no trap.
- Operands are captured at E0; rs_data/rt_data may change afterwards without effect.
- start while busy=1: ignored. The CPU must stall; no queueing.
- mthi/mtlo:
  - Write on the next enabled edge when busy=0 and start=0.
  - Ignored while busy=1.
  - If start=1 in the same cycle as mthi/mtlo, start wins and the write is dropped.
  - mthi and mtlo together: both registers are written.
- hi/lo hold their old values throughout RUN/FIX until the FIX edge.
- Reset mid-operation aborts immediately to reset values.

Optional Feature:
- Macro MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a single combinational 32x32 multiplier; the product is written at edge E1.
  - busy is high for exactly 1 cycle; RUN/FIX are skipped for multiplies.
  - Divide is unchanged.
- Undefined: multiplies take the iterative 33-cycle path described above, and no wide multiplier is inferred.

Decomposition:
- Package mips_muldiv_pkg:
  - op enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - state enum (S_IDLE, S_RUN, S_FIX).
  - Constants ITER=32 and DIV0_LO=32'hFFFFFFFF.
- Natural sub-module: muldiv_div_step.
  - Purely combinational single restoring-divide step: remainder/quotient in, shifted pair out.
  - Instantiated once inside mips_muldiv.
- Counter, FSM, sign handling and HI/LO stay in the top.

Test Plan:
- MULTU rs=32'hFFFFFFFF, rt=32'hFFFFFFFF -> busy high 33 cycles; hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT rs=-7 (32'hFFFFFFF9), rt=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. With MULDIV_FAST_MULT_EN: same result, busy for 1 cycle.
- DIV rs=-7, rt=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIVU rs=32'h12345678, rt=0 -> hi=32'h12345678, lo=32'hFFFFFFFF. DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
- Concurrency: start at cycle 5 followed by start+mthi at cycle 10 (busy) -> second start and mthi ignored, first result intact. Hold clk_enable=0 for 10 cycles mid-RUN -> completion is delayed by exactly 10 cycles.
- Reset=0 asserted at iteration 15 of a DIV -> hi=lo=0 and busy=0 immediately. After release, mtlo with wdata=32'hCAFEF00D -> lo=32'hCAFEF00D on the next edge.
